// File: rtl/spi_ram_arbiter_if.sv
// Signal bundle between the SPI-side command/data path, the local host requester and the RAM port.
// The arbiter connects through the slave modport; the requesters/RAM side uses master.
interface spi_ram_arbiter_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
);
    logic                  rx_valid;
    logic [9:0]            rx_data;
    logic                  tx_valid;
    logic [DATA_WIDTH-1:0] tx_data;

    logic                  host_req;
    logic                  host_we;
    logic [ADDR_WIDTH-1:0] host_addr;
    logic [DATA_WIDTH-1:0] host_wdata;
    logic                  host_gnt;
    logic                  host_rvalid;
    logic [DATA_WIDTH-1:0] host_rdata;

    logic                  ram_en;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic [DATA_WIDTH-1:0] ram_rdata;

    modport master (
        output rx_valid, rx_data, host_req, host_we, host_addr, host_wdata, ram_rdata,
        input  tx_valid, tx_data, host_gnt, host_rvalid, host_rdata,
               ram_en, ram_we, ram_addr, ram_wdata
    );

    modport slave (
        input  rx_valid, rx_data, host_req, host_we, host_addr, host_wdata, ram_rdata,
        output tx_valid, tx_data, host_gnt, host_rvalid, host_rdata,
               ram_en, ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/spi_ram_arbiter.sv
// Decodes SPI command words into RAM accesses and shares the single RAM port
// round-robin with a local host requester.
//
//   state    | meaning
//   ---------+-----------------------------------------------
//   IDLE     | no access in flight; arbitrate SPI slot vs host
//   ACC_SPI  | SPI access on the RAM port (ram_en high)
//   ACC_HOST | host access on the RAM port (ram_en, host_gnt)
//   RD_SPI   | RAM read data present; capture into tx_data
//   RD_HOST  | RAM read data present; capture into host_rdata
module spi_ram_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input logic          clk,
    input logic          rst,
    spi_ram_arbiter_if.slave bus
);
    typedef enum logic [2:0] {IDLE, ACC_SPI, ACC_HOST, RD_SPI, RD_HOST} state_t;

    state_t                state;
    state_t                state_nxt;
    logic                  rx_prev;
    logic                  accept;
    logic [1:0]            opcode;
    logic [7:0]            payload;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  spi_pend;
    logic                  spi_rd;
    logic [7:0]            spi_data;
    logic                  last_spi;
    logic                  grant_spi;
    logic                  grant_host;

    assign accept  = bus.rx_valid && !rx_prev;
    assign opcode  = bus.rx_data[9:8];
    assign payload = bus.rx_data[7:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        grant_spi  = 1'b0;
        grant_host = 1'b0;
        case (state)
            IDLE: begin
                // On a tie the requester not served last wins.
                if (spi_pend && bus.host_req) begin
                    grant_host = !last_spi ? 1'b0 : 1'b1;
                    grant_spi  = !grant_host;
                end else begin
                    grant_spi  = spi_pend;
                    grant_host = bus.host_req;
                end
                if (grant_spi)       state_nxt = ACC_SPI;
                else if (grant_host) state_nxt = ACC_HOST;
            end
            ACC_SPI:  state_nxt = bus.ram_we ? IDLE : RD_SPI;
            ACC_HOST: state_nxt = bus.ram_we ? IDLE : RD_HOST;
            RD_SPI:   state_nxt = IDLE;
            RD_HOST:  state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_prev         <= 1'b0;
            wr_addr         <= '0;
            rd_addr         <= '0;
            spi_pend        <= 1'b0;
            spi_rd          <= 1'b0;
            spi_data        <= '0;
            last_spi        <= 1'b0;
            bus.ram_en      <= 1'b0;
            bus.ram_we      <= 1'b0;
            bus.ram_addr    <= '0;
            bus.ram_wdata   <= '0;
            bus.host_gnt    <= 1'b0;
            bus.host_rvalid <= 1'b0;
            bus.host_rdata  <= '0;
            bus.tx_valid    <= 1'b0;
            bus.tx_data     <= '0;
        end else begin
            rx_prev         <= bus.rx_valid;
            bus.ram_en      <= 1'b0;
            bus.host_gnt    <= 1'b0;
            bus.host_rvalid <= 1'b0;

            if (grant_spi) begin
                spi_pend      <= 1'b0;
                last_spi      <= 1'b1;
                bus.ram_en    <= 1'b1;
                bus.ram_we    <= !spi_rd;
                bus.ram_addr  <= spi_rd ? rd_addr : wr_addr;
                bus.ram_wdata <= DATA_WIDTH'(spi_data);
            end
            if (grant_host) begin
                last_spi      <= 1'b0;
                bus.ram_en    <= 1'b1;
                bus.ram_we    <= bus.host_we;
                bus.ram_addr  <= bus.host_addr;
                bus.ram_wdata <= bus.host_wdata;
                bus.host_gnt  <= 1'b1;
            end

            if (accept) begin
                bus.tx_valid <= 1'b0;
                case (opcode)
                    2'b00: wr_addr <= ADDR_WIDTH'(payload);
                    2'b01: begin
                        spi_pend <= 1'b1;
                        spi_rd   <= 1'b0;
                        spi_data <= payload;
                    end
                    2'b10: rd_addr <= ADDR_WIDTH'(payload);
                    default: begin
                        spi_pend <= 1'b1;
                        spi_rd   <= 1'b1;
                    end
                endcase
            end

            if (state == RD_SPI) begin
                bus.tx_data  <= bus.ram_rdata;
                bus.tx_valid <= 1'b1;
            end
            if (state == RD_HOST) begin
                bus.host_rdata  <= bus.ram_rdata;
                bus.host_rvalid <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Directed bench for spi_ram_arbiter: behavioural RAM on the port, hand-computed expectations.
module tb_spi_ram_arbiter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_ram_arbiter_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) bus ();
    spi_ram_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [7:0] mem [256];
    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int c0;
    int wr_count = 0;
    int rd_count = 0;
    int wr_cyc_last = -1;
    logic [7:0] wr_addr_last = '0;
    logic [7:0] wr_data_last = '0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.ram_en === 1'b1) begin
            if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
            else            bus.ram_rdata     <= mem[bus.ram_addr];
        end
    end

    always @(negedge clk) begin
        if (bus.ram_en === 1'b1 && bus.ram_we === 1'b1) begin
            wr_count     = wr_count + 1;
            wr_addr_last = bus.ram_addr;
            wr_data_last = bus.ram_wdata;
            wr_cyc_last  = cyc;
        end
        if (bus.ram_en === 1'b1 && bus.ram_we === 1'b0) rd_count = rd_count + 1;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [9:0] w, input int hold);
        bus.rx_valid = 1'b1;
        bus.rx_data  = w;
        c0 = cyc;
        repeat (hold) @(negedge clk);
        bus.rx_valid = 1'b0;
        idle(3);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.rx_valid = 1'b0; bus.rx_data = '0;
        bus.host_req = 1'b0; bus.host_we = 1'b0; bus.host_addr = '0; bus.host_wdata = '0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        idle(2);
        rst = 1'b0;
        idle(1);
        bus.host_req = 1'b1; bus.host_we = 1'b1; bus.host_addr = 8'h20; bus.host_wdata = 8'h77;
        @(negedge clk);
        bus.host_req = 1'b0;
        vectors++;
        if ({bus.ram_en, bus.host_gnt} !== 2'b11) begin
            miscompares++;
            $display("FAIL reset_pre_gnt: en/gnt=%b expected 11", {bus.ram_en, bus.host_gnt});
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({bus.tx_valid, bus.host_gnt, bus.host_rvalid, bus.ram_en, bus.ram_we} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: tx_v/gnt/rv/en/we=%b expected 00000",
                     {bus.tx_valid, bus.host_gnt, bus.host_rvalid, bus.ram_en, bus.ram_we});
        end
        vectors++;
        if ({bus.tx_data, bus.host_rdata, bus.ram_addr, bus.ram_wdata} !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_data: buses=%h expected 00000000",
                     {bus.tx_data, bus.host_rdata, bus.ram_addr, bus.ram_wdata});
        end
        @(negedge clk);
        rst = 1'b0;
        idle(2);
        vectors++;
        if (mem[8'h20] !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_discard: mem[20]=%h expected 00", mem[8'h20]);
        end
    endtask

    task automatic test_spi_write_read;
        int w0;
        int r0;
        w0 = wr_count;
        send(10'h005, 12);
        vectors++;
        if (wr_count !== w0) begin
            miscompares++;
            $display("FAIL op00_no_access: writes=%0d expected %0d", wr_count, w0);
        end
        send(10'h1A7, 12);
        vectors++;
        if (wr_count !== w0 + 1 || wr_addr_last !== 8'h05 || wr_data_last !== 8'hA7) begin
            miscompares++;
            $display("FAIL spi_write: writes=%0d addr=%h data=%h expected %0d 05 A7",
                     wr_count, wr_addr_last, wr_data_last, w0 + 1);
        end
        vectors++;
        if (wr_cyc_last !== c0 + 2) begin
            miscompares++;
            $display("FAIL spi_write_latency: cycle=%0d expected %0d", wr_cyc_last, c0 + 2);
        end
        r0 = rd_count;
        send(10'h205, 12);
        vectors++;
        if (wr_count !== w0 + 1 || rd_count !== r0) begin
            miscompares++;
            $display("FAIL op10_no_access: writes=%0d reads=%0d expected %0d %0d",
                     wr_count, rd_count, w0 + 1, r0);
        end
        bus.rx_valid = 1'b1;
        bus.rx_data  = 10'h300;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (i == 2) begin
                vectors++;
                if ({bus.ram_en, bus.ram_we, bus.ram_addr} !== {2'b10, 8'h05}) begin
                    miscompares++;
                    $display("FAIL spi_read_issue: en/we/addr=%b/%b/%h expected 1/0/05",
                             bus.ram_en, bus.ram_we, bus.ram_addr);
                end
            end
            if (i == 3) begin
                vectors++;
                if (bus.tx_valid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL tx_early: tx_valid=%b expected 0 at +3", bus.tx_valid);
                end
            end
            if (i == 4 || i == 12) begin
                vectors++;
                if ({bus.tx_valid, bus.tx_data} !== {1'b1, 8'hA7}) begin
                    miscompares++;
                    $display("FAIL tx_data_+%0d: tx_valid/data=%b/%h expected 1/A7",
                             i, bus.tx_valid, bus.tx_data);
                end
            end
        end
        bus.rx_valid = 1'b0;
        idle(3);
        bus.rx_valid = 1'b1;
        bus.rx_data  = 10'h205;
        @(negedge clk);
        vectors++;
        if (bus.tx_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL tx_clear: tx_valid=%b expected 0", bus.tx_valid);
        end
        idle(3);
        bus.rx_valid = 1'b0;
        idle(3);
    endtask

    task automatic test_host_read;
        bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_addr = 8'h05;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (i == 1) begin
                bus.host_req = 1'b0;
                vectors++;
                if ({bus.host_gnt, bus.ram_en, bus.ram_we, bus.ram_addr} !== {3'b110, 8'h05}) begin
                    miscompares++;
                    $display("FAIL host_gnt: gnt/en/we/addr=%b/%b/%b/%h expected 1/1/0/05",
                             bus.host_gnt, bus.ram_en, bus.ram_we, bus.ram_addr);
                end
            end
            if (i == 2) begin
                vectors++;
                if ({bus.host_gnt, bus.host_rvalid} !== 2'b00) begin
                    miscompares++;
                    $display("FAIL host_gap: gnt/rvalid=%b expected 00", {bus.host_gnt, bus.host_rvalid});
                end
            end
            if (i == 3) begin
                vectors++;
                if ({bus.host_rvalid, bus.host_rdata} !== {1'b1, 8'hA7}) begin
                    miscompares++;
                    $display("FAIL host_rvalid: rvalid/rdata=%b/%h expected 1/A7",
                             bus.host_rvalid, bus.host_rdata);
                end
            end
            if (i == 4) begin
                vectors++;
                if ({bus.host_rvalid, bus.host_rdata} !== {1'b0, 8'hA7}) begin
                    miscompares++;
                    $display("FAIL host_rdata_hold: rvalid/rdata=%b/%h expected 0/A7",
                             bus.host_rvalid, bus.host_rdata);
                end
            end
        end
        idle(2);
    endtask

    task automatic test_held_rx;
        int w0;
        w0 = wr_count;
        send(10'h155, 20);
        vectors++;
        if (wr_count !== w0 + 1 || wr_addr_last !== 8'h05 || wr_data_last !== 8'h55) begin
            miscompares++;
            $display("FAIL held_rx: writes=%0d addr=%h data=%h expected %0d 05 55",
                     wr_count - w0, wr_addr_last, wr_data_last, 1);
        end
    endtask

    task automatic test_simultaneous;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        bus.rx_valid = 1'b1; bus.rx_data = 10'h1C3;
        @(negedge clk);
        bus.host_req = 1'b1; bus.host_we = 1'b1; bus.host_addr = 8'h10; bus.host_wdata = 8'h5A;
        @(negedge clk);
        vectors++;
        if ({bus.ram_en, bus.ram_we, bus.host_gnt, bus.ram_addr, bus.ram_wdata} !== {3'b110, 8'h00, 8'hC3}) begin
            miscompares++;
            $display("FAIL tie1_spi_first: en/we/gnt=%b addr=%h data=%h expected 110 00 C3",
                     {bus.ram_en, bus.ram_we, bus.host_gnt}, bus.ram_addr, bus.ram_wdata);
        end
        @(negedge clk);
        vectors++;
        if (bus.ram_en !== 1'b0) begin
            miscompares++;
            $display("FAIL tie1_idle_gap: ram_en=%b expected 0", bus.ram_en);
        end
        @(negedge clk);
        bus.host_req = 1'b0;
        vectors++;
        if ({bus.ram_en, bus.ram_we, bus.host_gnt, bus.ram_addr, bus.ram_wdata} !== {3'b111, 8'h10, 8'h5A}) begin
            miscompares++;
            $display("FAIL tie1_host_second: en/we/gnt=%b addr=%h data=%h expected 111 10 5A",
                     {bus.ram_en, bus.ram_we, bus.host_gnt}, bus.ram_addr, bus.ram_wdata);
        end
        bus.rx_valid = 1'b0;
        idle(3);
        send(10'h1E1, 4);
        bus.rx_valid = 1'b1; bus.rx_data = 10'h1F0;
        @(negedge clk);
        bus.host_req = 1'b1; bus.host_we = 1'b1; bus.host_addr = 8'h11; bus.host_wdata = 8'h66;
        @(negedge clk);
        bus.host_req = 1'b0;
        vectors++;
        if ({bus.ram_en, bus.host_gnt, bus.ram_addr, bus.ram_wdata} !== {2'b11, 8'h11, 8'h66}) begin
            miscompares++;
            $display("FAIL tie2_host_first: en/gnt=%b addr=%h data=%h expected 11 11 66",
                     {bus.ram_en, bus.host_gnt}, bus.ram_addr, bus.ram_wdata);
        end
        idle(2);
        vectors++;
        if ({bus.ram_en, bus.ram_we, bus.host_gnt, bus.ram_addr, bus.ram_wdata} !== {3'b110, 8'h00, 8'hF0}) begin
            miscompares++;
            $display("FAIL tie2_spi_second: en/we/gnt=%b addr=%h data=%h expected 110 00 F0",
                     {bus.ram_en, bus.ram_we, bus.host_gnt}, bus.ram_addr, bus.ram_wdata);
        end
        bus.rx_valid = 1'b0;
        idle(3);
    endtask

    task automatic test_reset_during_read;
        int seen;
        send(10'h210, 4);
        bus.rx_valid = 1'b1; bus.rx_data = 10'h300;
        idle(3);
        rst = 1'b1;
        bus.rx_valid = 1'b0;
        #1;
        vectors++;
        if ({bus.tx_valid, bus.ram_en} !== 2'b00) begin
            miscompares++;
            $display("FAIL rd_reset_now: tx_valid/ram_en=%b expected 00", {bus.tx_valid, bus.ram_en});
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.tx_valid !== 1'b0) seen++;
        end
        vectors++;
        if (seen !== 0) begin
            miscompares++;
            $display("FAIL rd_reset_no_tx: tx_valid cycles=%0d expected 0", seen);
        end
        bus.rx_valid = 1'b1; bus.rx_data = 10'h300;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            if (i == 2) begin
                vectors++;
                if ({bus.ram_en, bus.ram_we, bus.ram_addr} !== {2'b10, 8'h00}) begin
                    miscompares++;
                    $display("FAIL rd_after_reset_addr: en/we/addr=%b/%b/%h expected 1/0/00",
                             bus.ram_en, bus.ram_we, bus.ram_addr);
                end
            end
            if (i == 4) begin
                vectors++;
                if ({bus.tx_valid, bus.tx_data} !== {1'b1, 8'hF0}) begin
                    miscompares++;
                    $display("FAIL rd_after_reset_data: tx_valid/data=%b/%h expected 1/F0",
                             bus.tx_valid, bus.tx_data);
                end
            end
        end
        bus.rx_valid = 1'b0;
        idle(3);
    endtask

    initial begin
        test_reset();
        test_spi_write_read();
        test_host_read();
        test_held_rx();
        test_simultaneous();
        test_reset_during_read();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
